// File: rtl/dmem_if.sv
// Load/store port bundle for dmem; bit 0 of each bus is the MSB.
interface dmem_if;
  logic [0:31] i_addr;
  logic [0:31] i_data_in;
  logic [0:31] o_data_out;
  logic        i_write_enable;
  logic        i_byte;
  logic        i_half_word;
  logic        i_sign_extend;

  modport slave (
    input  i_addr, i_data_in, i_write_enable, i_byte, i_half_word, i_sign_extend,
    output o_data_out
  );

  modport master (
    output i_addr, i_data_in, i_write_enable, i_byte, i_half_word, i_sign_extend,
    input  o_data_out
  );
endinterface

// File: rtl/dmem.sv
// Big-endian byte-addressed data memory: combinational loads (zero latency),
// stores commit on the rising edge unless reset is high; never stalls.
module dmem #(
  parameter int SIZE = 16384
) (
  input logic   clock,
  input logic   reset,
  dmem_if.slave bus
);
  localparam int AW = $clog2(SIZE);

  logic [7:0] mem [0:SIZE-1];

  logic [AW-1:0] w_a0, w_a1, w_a2, w_a3;
  logic [7:0]    w_b0, w_b1, w_b2, w_b3;
  logic [0:31]   w_data_out;

  // Index arithmetic is AW bits wide so successive bytes wrap mod SIZE.
  assign w_a0 = bus.i_addr[32-AW:31];
  assign w_a1 = w_a0 + AW'(1);
  assign w_a2 = w_a0 + AW'(2);
  assign w_a3 = w_a0 + AW'(3);

  assign w_b0 = mem[w_a0];
  assign w_b1 = mem[w_a1];
  assign w_b2 = mem[w_a2];
  assign w_b3 = mem[w_a3];

  always_comb begin
    w_data_out = {w_b0, w_b1, w_b2, w_b3};
    if (bus.i_byte) begin
      w_data_out = {{24{bus.i_sign_extend & w_b0[7]}}, w_b0};
    end else if (bus.i_half_word) begin
      w_data_out = {{16{bus.i_sign_extend & w_b0[7]}}, w_b0, w_b1};
    end
  end

  assign bus.o_data_out = w_data_out;

  always_ff @(posedge clock) begin
    if (!reset && bus.i_write_enable) begin
      if (bus.i_byte) begin
        mem[w_a0] <= bus.i_data_in[24:31];
      end else if (bus.i_half_word) begin
        mem[w_a0] <= bus.i_data_in[16:23];
        mem[w_a1] <= bus.i_data_in[24:31];
      end else begin
        mem[w_a0] <= bus.i_data_in[0:7];
        mem[w_a1] <= bus.i_data_in[8:15];
        mem[w_a2] <= bus.i_data_in[16:23];
        mem[w_a3] <= bus.i_data_in[24:31];
      end
    end
  end
endmodule

// File: tb/tb_dmem.sv
// Directed bench for dmem: width/extension loads, stores, reset inhibit, wrap.
module tb_dmem;
  localparam int SIZE = 16384;

  logic clk;
  logic rst;
  int   tests_run;
  int   fail_cnt;

  dmem_if bus ();

  dmem #(.SIZE(SIZE)) u_dmem (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic b, input logic h);
    bus.i_addr         = a;
    bus.i_data_in      = d;
    bus.i_byte         = b;
    bus.i_half_word    = h;
    bus.i_write_enable = 1'b1;
    @(posedge clk);
    #1;
    bus.i_write_enable = 1'b0;
  endtask

  task automatic load_chk(input string tag, input logic [31:0] a, input logic b, input logic h,
                          input logic sx, input logic [31:0] exp);
    bus.i_addr        = a;
    bus.i_byte        = b;
    bus.i_half_word   = h;
    bus.i_sign_extend = sx;
    #1;
    check(tag, bus.o_data_out, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests_run          = 0;
    fail_cnt           = 0;
    rst                = 1'b1;
    bus.i_addr         = '0;
    bus.i_data_in      = '0;
    bus.i_write_enable = 1'b0;
    bus.i_byte         = 1'b0;
    bus.i_half_word    = 1'b0;
    bus.i_sign_extend  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Preload 80 7F 12 34 at 0x2000 byte by byte.
    store(32'h2000, 32'h0000_0080, 1'b1, 1'b0);
    store(32'h2001, 32'h0000_007F, 1'b1, 1'b0);
    store(32'h2002, 32'h0000_0012, 1'b1, 1'b0);
    store(32'h2003, 32'h0000_0034, 1'b1, 1'b0);
    load_chk("ld_word",    32'h2000, 1'b0, 1'b0, 1'b0, 32'h807F_1234);
    load_chk("ld_word_sx", 32'h2000, 1'b0, 1'b0, 1'b1, 32'h807F_1234);
    load_chk("ld_half_zx", 32'h2000, 1'b0, 1'b1, 1'b0, 32'h0000_807F);
    load_chk("ld_half_sx", 32'h2000, 1'b0, 1'b1, 1'b1, 32'hFFFF_807F);
    load_chk("ld_byte_zx", 32'h2000, 1'b1, 1'b0, 1'b0, 32'h0000_0080);
    load_chk("ld_byte_sx", 32'h2000, 1'b1, 1'b0, 1'b1, 32'hFFFF_FF80);
    load_chk("byte_prio",  32'h2000, 1'b1, 1'b1, 1'b0, 32'h0000_0080);

    // Word stores.
    store(32'h2000, 32'h0000_0001, 1'b0, 1'b0);
    store(32'h2004, 32'hFFFF_FFFF, 1'b0, 1'b0);
    load_chk("st_word_a", 32'h2000, 1'b0, 1'b0, 1'b0, 32'h0000_0001);
    load_chk("st_word_b", 32'h2004, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
    load_chk("unaligned", 32'h2001, 1'b0, 1'b0, 1'b0, 32'h0000_01FF);

    // Half-word stores over known background.
    store(32'h2008, 32'hAABB_CCDD, 1'b0, 1'b0);
    store(32'h200C, 32'h1122_3344, 1'b0, 1'b0);
    store(32'h2008, 32'h0000_0001, 1'b0, 1'b1);
    store(32'h200C, 32'hFFFF_FFFF, 1'b0, 1'b1);
    load_chk("st_half_a",    32'h2008, 1'b0, 1'b1, 1'b0, 32'h0000_0001);
    load_chk("st_half_b_zx", 32'h200C, 1'b0, 1'b1, 1'b0, 32'h0000_FFFF);
    load_chk("st_half_b_sx", 32'h200C, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    load_chk("half_keep_a",  32'h2008, 1'b0, 1'b0, 1'b0, 32'h0001_CCDD);
    load_chk("half_keep_b",  32'h200C, 1'b0, 1'b0, 1'b0, 32'hFFFF_3344);

    // Byte stores over known background.
    store(32'h2010, 32'h5566_7788, 1'b0, 1'b0);
    store(32'h2014, 32'h1234_5678, 1'b0, 1'b0);
    store(32'h2010, 32'h0000_0001, 1'b1, 1'b0);
    store(32'h2014, 32'hFFFF_FFFF, 1'b1, 1'b0);
    load_chk("st_byte_a",    32'h2010, 1'b1, 1'b0, 1'b0, 32'h0000_0001);
    load_chk("st_byte_b_zx", 32'h2014, 1'b1, 1'b0, 1'b0, 32'h0000_00FF);
    load_chk("st_byte_b_sx", 32'h2014, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
    load_chk("byte_keep_a",  32'h2010, 1'b0, 1'b0, 1'b0, 32'h0166_7788);
    load_chk("byte_keep_b",  32'h2014, 1'b0, 1'b0, 1'b0, 32'hFF34_5678);

    // Reset inhibits the store; contents survive.
    store(32'h2020, 32'h0102_0304, 1'b0, 1'b0);
    rst = 1'b1;
    store(32'h2020, 32'hDEAD_BEEF, 1'b0, 1'b0);
    rst = 1'b0;
    load_chk("rst_inhibit", 32'h2020, 1'b0, 1'b0, 1'b0, 32'h0102_0304);

    // Edge timing: old data visible while write_enable is high, new after the edge.
    bus.i_addr         = 32'h2020;
    bus.i_data_in      = 32'hDEAD_BEEF;
    bus.i_byte         = 1'b0;
    bus.i_half_word    = 1'b0;
    bus.i_write_enable = 1'b1;
    #1;
    check("pre_edge", bus.o_data_out, 32'h0102_0304);
    @(posedge clk);
    #1;
    bus.i_write_enable = 1'b0;
    check("post_edge", bus.o_data_out, 32'hDEAD_BEEF);

    // Wrap-around at the top of memory.
    store(SIZE - 1, 32'h1122_3344, 1'b0, 1'b0);
    load_chk("wrap_b_top", SIZE - 1, 1'b1, 1'b0, 1'b0, 32'h0000_0011);
    load_chk("wrap_b0",    32'h0,    1'b1, 1'b0, 1'b0, 32'h0000_0022);
    load_chk("wrap_b1",    32'h1,    1'b1, 1'b0, 1'b0, 32'h0000_0033);
    load_chk("wrap_b2",    32'h2,    1'b1, 1'b0, 1'b0, 32'h0000_0044);
    load_chk("wrap_word",  SIZE - 1, 1'b0, 1'b0, 1'b0, 32'h1122_3344);
    load_chk("addr_alias", 32'h0001_2000 + SIZE, 1'b0, 1'b0, 1'b0, 32'h0000_0001);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end
endmodule
